// File: rtl/raisin64_regfile_pkg.sv
// Shared types and constants for the architectural register file and scoreboard.
package raisin64_regfile_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 64;
    localparam int unsigned RN_W  = 6;

    typedef logic [RN_W-1:0] rn_t;
    typedef logic [XLEN-1:0] xword_t;

    localparam rn_t REG_ZERO = 6'd0;
    localparam rn_t REG_LINK = 6'd63;

    function automatic logic [NREGS-1:0] rn_onehot(input rn_t rn);
        logic [NREGS-1:0] v;
        v = '0;
        if (rn != REG_ZERO) v[rn] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write busy vector: issue sets, commit clears, flush wipes; sticky protocol error.
// Optional REGFILE_BYPASS_EN hides a register being cleared this cycle from busy lookups.
module regfile_scoreboard
    import raisin64_regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  rn_t  write_rn,
    input  rn_t  rs1_rn,
    input  rn_t  rs2_rn,
    input  rn_t  rs3_rn,
    input  logic issue_valid,
    input  rn_t  issue_rd,
    input  logic issue_rd2_valid,
    input  rn_t  issue_rd2,
    input  logic sb_flush,
    output logic rs1_busy,
    output logic rs2_busy,
    output logic rs3_busy,
    output logic rd_busy,
    output logic sb_error
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic             sb_error_q, sb_error_d;
    logic [NREGS-1:0] set_vec, clr_vec, vis_busy;
    logic             rd2_hit, issue_err, commit_err;

    always_comb begin
        set_vec = '0;
        clr_vec = rn_onehot(write_rn);
        if (issue_valid) begin
            set_vec = rn_onehot(issue_rd);
            if (issue_rd2_valid) set_vec = set_vec | rn_onehot(issue_rd2);
        end
`ifdef REGFILE_BYPASS_EN
        vis_busy = busy_q & ~clr_vec;
`else
        vis_busy = busy_q;
`endif
    end

    always_comb begin
        rs1_busy = vis_busy[rs1_rn];
        rs2_busy = vis_busy[rs2_rn];
        rs3_busy = vis_busy[rs3_rn];
        rd2_hit  = issue_rd2_valid && vis_busy[issue_rd2];
        rd_busy  = vis_busy[issue_rd] || rd2_hit;
    end

    // Set applied after clear so a re-issued destination stays pending; flush overrides both.
    always_comb begin
        issue_err  = issue_valid && (rd_busy || sb_flush);
        commit_err = (write_rn != REG_ZERO) && !busy_q[write_rn];
        sb_error_d = sb_error_q || issue_err || commit_err;
        if (sb_flush) busy_d = '0;
        else          busy_d = (busy_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            sb_error_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            sb_error_q <= sb_error_d;
        end
    end

    assign sb_error = sb_error_q;

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file (single commit write port, three reads) plus scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to reads.
module regfile_sb #(
    parameter int unsigned XLEN  = raisin64_regfile_pkg::XLEN,
    parameter int unsigned NREGS = raisin64_regfile_pkg::NREGS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [XLEN-1:0]                      write_data,
    input  logic [raisin64_regfile_pkg::RN_W-1:0] write_rn,
    input  logic [raisin64_regfile_pkg::RN_W-1:0] rs1_rn,
    input  logic [raisin64_regfile_pkg::RN_W-1:0] rs2_rn,
    input  logic [raisin64_regfile_pkg::RN_W-1:0] rs3_rn,
    output logic [XLEN-1:0]                      rs1_data,
    output logic [XLEN-1:0]                      rs2_data,
    output logic [XLEN-1:0]                      rs3_data,
    output logic                                 rs1_busy,
    output logic                                 rs2_busy,
    output logic                                 rs3_busy,
    input  logic                                 issue_valid,
    input  logic [raisin64_regfile_pkg::RN_W-1:0] issue_rd,
    input  logic                                 issue_rd2_valid,
    input  logic [raisin64_regfile_pkg::RN_W-1:0] issue_rd2,
    output logic                                 rd_busy,
    input  logic                                 sb_flush,
    output logic                                 sb_error
);

    import raisin64_regfile_pkg::rn_t;
    import raisin64_regfile_pkg::REG_ZERO;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    function automatic logic [XLEN-1:0] read_port(input rn_t rn);
        logic [XLEN-1:0] v;
        v = regs_q[rn];
        if (rn == REG_ZERO) v = '0;
`ifdef REGFILE_BYPASS_EN
        else if (rn == write_rn) v = write_data;
`endif
        return v;
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (write_rn != REG_ZERO) regs_d[write_rn] = write_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs1_data = read_port(rs1_rn);
        rs2_data = read_port(rs2_rn);
        rs3_data = read_port(rs3_rn);
    end

    regfile_scoreboard u_scoreboard (
        .clk             (clk),
        .rst_n           (rst_n),
        .write_rn        (write_rn),
        .rs1_rn          (rs1_rn),
        .rs2_rn          (rs2_rn),
        .rs3_rn          (rs3_rn),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_rd2_valid (issue_rd2_valid),
        .issue_rd2       (issue_rd2),
        .sb_flush        (sb_flush),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .rs3_busy        (rs3_busy),
        .rd_busy         (rd_busy),
        .sb_error        (sb_error)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] write_data;
    logic [5:0]  write_rn, rs1_rn, rs2_rn, rs3_rn;
    logic [63:0] rs1_data, rs2_data, rs3_data;
    logic        rs1_busy, rs2_busy, rs3_busy;
    logic        issue_valid, issue_rd2_valid;
    logic [5:0]  issue_rd, issue_rd2;
    logic        rd_busy, sb_flush, sb_error;

    int total = 0;
    int bad   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(64), .NREGS(64)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .write_data      (write_data),
        .write_rn        (write_rn),
        .rs1_rn          (rs1_rn),
        .rs2_rn          (rs2_rn),
        .rs3_rn          (rs3_rn),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .rs3_data        (rs3_data),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .rs3_busy        (rs3_busy),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_rd2_valid (issue_rd2_valid),
        .issue_rd2       (issue_rd2),
        .rd_busy         (rd_busy),
        .sb_flush        (sb_flush),
        .sb_error        (sb_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; caller then drives inputs and waits #1 to check.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_rn = 6'd0; write_data = '0;
        issue_valid = 1'b0; issue_rd = 6'd0; issue_rd2_valid = 1'b0; issue_rd2 = 6'd0;
        sb_flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rs1_rn = 6'd5; rs2_rn = 6'd63; rs3_rn = 6'd0;
        #3;
        chk("rst_rs1_data", rs1_data, 64'h0);
        chk("rst_rs2_data", rs2_data, 64'h0);
        chk("rst_busy", {61'h0, rs1_busy, rs2_busy, rs3_busy}, 64'h0);
        chk("rst_rd_busy", {63'h0, rd_busy}, 64'h0);
        chk("rst_sb_error", {63'h0, sb_error}, 64'h0);
        tick();
        rst_n = 1'b1;

        // r0 writes are ignored
        tick();
        write_rn = 6'd0; write_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        idle();
        #1;
        chk("r0_read", rs3_data, 64'h0);
        chk("r0_no_err", {63'h0, sb_error}, 64'h0);

        // issue rd=7 in cycle 0, writeback in cycle 3
        rs1_rn = 6'd7;
        issue_valid = 1'b1; issue_rd = 6'd7;
        #1;
        chk("c0_r7_busy", {63'h0, rs1_busy}, 64'h0);
        chk("c0_rd_busy", {63'h0, rd_busy}, 64'h0);
        tick(); idle(); #1;
        chk("c1_r7_busy", {63'h0, rs1_busy}, 64'h1);
        tick(); #1;
        chk("c2_r7_busy", {63'h0, rs1_busy}, 64'h1);
        chk("c2_r7_data", rs1_data, 64'h0);
        tick();
        write_rn = 6'd7; write_data = 64'h1234;
        #1;
        chk("c3_r7_busy", {63'h0, rs1_busy}, BYP ? 64'h0 : 64'h1);
        chk("c3_r7_data", rs1_data, BYP ? 64'h1234 : 64'h0);
        tick(); idle(); #1;
        chk("c4_r7_busy", {63'h0, rs1_busy}, 64'h0);
        chk("c4_r7_data", rs1_data, 64'h1234);

        // dual destination issue, two consecutive commits
        issue_valid = 1'b1; issue_rd = 6'd10; issue_rd2_valid = 1'b1; issue_rd2 = 6'd11;
        tick();
        issue_valid = 1'b0; issue_rd2_valid = 1'b0;
        rs1_rn = 6'd10; rs2_rn = 6'd11;
        #1;
        chk("dual_busy10", {63'h0, rs1_busy}, 64'h1);
        chk("dual_busy11", {63'h0, rs2_busy}, 64'h1);
        chk("dual_rd_busy", {63'h0, rd_busy}, 64'h1);
        write_rn = 6'd10; write_data = 64'hA;
        tick();
        write_rn = 6'd11; write_data = 64'hB; issue_rd = 6'd0;
        #1;
        chk("dual_r10_clr", {63'h0, rs1_busy}, 64'h0);
        chk("dual_r10_data", rs1_data, 64'hA);
        chk("dual_r11_mid", {63'h0, rs2_busy}, BYP ? 64'h0 : 64'h1);
        tick(); idle(); #1;
        chk("dual_r11_clr", {63'h0, rs2_busy}, 64'h0);
        chk("dual_r11_data", rs2_data, 64'hB);
        chk("dual_no_err", {63'h0, sb_error}, 64'h0);

        // same-cycle set and clear of r12: set wins, data lands
        issue_valid = 1'b1; issue_rd = 6'd12;
        tick();
        write_rn = 6'd12; write_data = 64'hC;
        rs1_rn = 6'd12;
        #1;
        chk("r12_rd_busy", {63'h0, rd_busy}, BYP ? 64'h0 : 64'h1);
        tick(); idle(); #1;
        chk("r12_data", rs1_data, 64'hC);
        chk("r12_busy", {63'h0, rs1_busy}, 64'h1);
        chk("r12_err", {63'h0, sb_error}, BYP ? 64'h0 : 64'h1);

        // asynchronous reset mid-cycle
        rs2_rn = 6'd7; rs3_rn = 6'd10;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_r12_busy", {63'h0, rs1_busy}, 64'h0);
        chk("arst_r12_data", rs1_data, 64'h0);
        chk("arst_r7_data", rs2_data, 64'h0);
        chk("arst_r10_data", rs3_data, 64'h0);
        chk("arst_err", {63'h0, sb_error}, 64'h0);
        tick();
        rst_n = 1'b1;

        // WAW issue to busy r20
        tick();
        issue_valid = 1'b1; issue_rd = 6'd20;
        tick();
        rs1_rn = 6'd20;
        #1;
        chk("waw_rd_busy", {63'h0, rd_busy}, 64'h1);
        chk("waw_err_pre", {63'h0, sb_error}, 64'h0);
        tick(); idle(); #1;
        chk("waw_err_post", {63'h0, sb_error}, 64'h1);
        chk("waw_r20_busy", {63'h0, rs1_busy}, 64'h1);
        issue_rd2_valid = 1'b1; issue_rd2 = 6'd20;
        #1;
        chk("rd2_busy", {63'h0, rd_busy}, 64'h1);
        issue_rd2_valid = 1'b0;
        #1;
        chk("rd2_invalid", {63'h0, rd_busy}, 64'h0);
        tick(); tick(); #1;
        chk("waw_err_sticky", {63'h0, sb_error}, 64'h1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // flush with simultaneous issue and write
        tick();
        issue_valid = 1'b1; issue_rd = 6'd3; issue_rd2_valid = 1'b1; issue_rd2 = 6'd4;
        tick();
        issue_rd = 6'd5; issue_rd2_valid = 1'b0; sb_flush = 1'b1;
        write_rn = 6'd3; write_data = 64'h33;
        rs1_rn = 6'd3; rs2_rn = 6'd4; rs3_rn = 6'd5;
        #1;
        chk("fl_pre_busy4", {63'h0, rs2_busy}, 64'h1);
        tick(); idle(); #1;
        chk("fl_busy", {61'h0, rs1_busy, rs2_busy, rs3_busy}, 64'h0);
        chk("fl_r3_data", rs1_data, 64'h33);
        chk("fl_err", {63'h0, sb_error}, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
